// File: rtl/flat_word_serializer_if.sv
// Handshake and data bundle between the parallel pipeline stage, the
// serializer, and the single-word downstream consumer.
interface flat_word_serializer_if #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 8
);
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic                             in_valid;
  logic                             in_ready;
  logic signed [WIDTH*STAGES-1:0]   data_in_flat;
  logic                             out_valid;
  logic                             out_ready;
  logic signed [WIDTH-1:0]          out_data;
  logic        [IDX_W-1:0]          out_index;
  logic                             out_last;
  logic                             busy;
  logic                             frame_done;

  // Serializer side.
  modport slave (
    input  in_valid, data_in_flat, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, busy, frame_done
  );

  // Environment side: producer of vectors and consumer of words.
  modport master (
    output in_valid, data_in_flat, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, busy, frame_done
  );
endinterface

// File: rtl/flat_word_serializer.sv
// Parallel-to-serial reader: captures a flat vector of STAGES words and
// streams them out word 0 first, one per valid/ready handshake.
module flat_word_serializer #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  flat_word_serializer_if.slave  bus
);
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state_q, state_d;
  logic [WIDTH*STAGES-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      frame_done_q, frame_done_d;

  logic                      valid;
  logic                      last;
  logic                      in_ready;
  logic                      load;
  logic                      xfer;
  logic [WIDTH-1:0]          word;

  assign valid    = (state_q == SEND);
  assign last     = valid && (idx_q == LAST_IDX);
  assign xfer     = valid && bus.out_ready;
  // Ready also on an accepted last word so the next frame follows with no bubble.
  assign in_ready = (state_q == IDLE) || (xfer && last);
  assign load     = bus.in_valid && in_ready;

  // Select the current word out of the held vector.
  always_comb begin
    word = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      if (idx_q == IDX_W'(j)) word = hold_q[WIDTH*j +: WIDTH];
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          hold_d  = bus.data_in_flat;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            frame_done_d = 1'b1;
            idx_d        = '0;
            if (load) hold_d = bus.data_in_flat;
            else      state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, held vector, word index and frame_done pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid;
  assign bus.busy       = valid;
  assign bus.out_data   = word;
  assign bus.out_index  = idx_q;
  assign bus.out_last   = last;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_flat_word_serializer.sv
// Bench for flat_word_serializer: directed scenarios on an 8x4 and a 16x1
// instance plus a randomized run against a queue-based frame model.
module tb_flat_word_serializer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flat_word_serializer_if #(.WIDTH(8),  .STAGES(4)) b4 ();
  flat_word_serializer_if #(.WIDTH(16), .STAGES(1)) b1 ();

  flat_word_serializer #(.WIDTH(8),  .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  flat_word_serializer #(.WIDTH(16), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.data_in_flat = '0;
    b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.data_in_flat = '0;
    repeat (3) cyc();
    #1;
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", b4.out_valid); end
    checks++; if (b4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", b4.busy); end
    checks++; if (b4.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", b4.out_data); end
    checks++; if (b4.out_index !== 2'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", b4.out_index); end
    checks++; if (b4.out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", b4.out_last); end
    checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", b4.in_ready); end
    checks++; if (b4.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", b4.frame_done); end
    checks++; if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_s1 got v=%b r=%b exp v=0 r=1", b1.out_valid, b1.in_ready); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    cyc();
    b4.in_valid = 1'b1; b4.data_in_flat = 32'h04030201; b4.out_ready = 1'b1;
    #1;
    checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL basic_load_ready got %b exp 1", b4.in_ready); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      b4.in_valid = 1'b0;
      #1;
      exp = 8'(k + 1);
      checks++; if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid k=%0d got %b exp 1", k, b4.out_valid); end
      checks++; if (b4.out_data !== exp) begin errors++; $display("FAIL basic_data k=%0d got %h exp %h", k, b4.out_data, exp); end
      checks++; if (b4.out_index !== 2'(k)) begin errors++; $display("FAIL basic_index k=%0d got %0d exp %0d", k, b4.out_index, k); end
      checks++; if (b4.out_last !== (k == 3)) begin errors++; $display("FAIL basic_last k=%0d got %b exp %b", k, b4.out_last, (k == 3)); end
      checks++; if (b4.frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_early k=%0d got %b exp 0", k, b4.frame_done); end
    end
    cyc(); #1;
    checks++; if (b4.frame_done !== 1'b1) begin errors++; $display("FAIL basic_fd got %b exp 1", b4.frame_done); end
    checks++; if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle got v=%b r=%b exp v=0 r=1", b4.out_valid, b4.in_ready); end
    cyc(); #1;
    checks++; if (b4.frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_pulse got %b exp 0", b4.frame_done); end
  endtask

  task automatic test_signed();
    logic [7:0] exp_w [4];
    exp_w[0] = 8'h01; exp_w[1] = 8'h7F; exp_w[2] = 8'hFF; exp_w[3] = 8'h80;
    cyc();
    b4.in_valid = 1'b1; b4.data_in_flat = 32'h80FF7F01; b4.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      b4.in_valid = 1'b0; b4.data_in_flat = 32'h5A5A5A5A;
      #1;
      checks++; if (b4.out_data !== exp_w[k]) begin errors++; $display("FAIL signed_data k=%0d got %h exp %h", k, b4.out_data, exp_w[k]); end
    end
    checks++; if ($signed(b4.out_data) !== -8'sd128) begin errors++; $display("FAIL signed_value got %0d exp -128", $signed(b4.out_data)); end
    repeat (2) cyc();
  endtask

  task automatic test_backpressure();
    cyc();
    b4.in_valid = 1'b1; b4.data_in_flat = 32'h04030201; b4.out_ready = 1'b1;
    cyc();
    b4.in_valid = 1'b0;
    #1;
    checks++; if (b4.out_data !== 8'h01) begin errors++; $display("FAIL bp_word0 got %h exp 01", b4.out_data); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      b4.out_ready = 1'b0; b4.in_valid = 1'b1; b4.data_in_flat = 32'hAAAAAAAA;
      #1;
      checks++; if (b4.out_data !== 8'h02 || b4.out_index !== 2'd1 || b4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall k=%0d got d=%h i=%0d v=%b exp d=02 i=1 v=1", k, b4.out_data, b4.out_index, b4.out_valid); end
      checks++; if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready k=%0d got %b exp 0", k, b4.in_ready); end
    end
    b4.in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cyc();
      b4.out_ready = 1'b1; b4.in_valid = 1'b0;
      #1;
      checks++; if (b4.out_data !== 8'(k + 1) || b4.out_index !== 2'(k)) begin errors++; $display("FAIL bp_resume k=%0d got d=%h i=%0d exp d=%h i=%0d", k, b4.out_data, b4.out_index, 8'(k + 1), k); end
    end
    cyc(); #1;
    checks++; if (b4.out_valid !== 1'b0 || b4.frame_done !== 1'b1) begin errors++; $display("FAIL bp_end got v=%b fd=%b exp v=0 fd=1", b4.out_valid, b4.frame_done); end
    cyc();
  endtask

  task automatic test_back_to_back();
    cyc();
    b4.in_valid = 1'b1; b4.data_in_flat = 32'h04030201; b4.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      b4.in_valid = 1'b1; b4.data_in_flat = 32'h08070605;
      #1;
      checks++; if (b4.out_data !== 8'(k + 1)) begin errors++; $display("FAIL b2b_a k=%0d got %h exp %h", k, b4.out_data, 8'(k + 1)); end
      checks++; if (b4.in_ready !== (k == 3)) begin errors++; $display("FAIL b2b_in_ready k=%0d got %b exp %b", k, b4.in_ready, (k == 3)); end
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      b4.in_valid = 1'b0; b4.data_in_flat = 32'hDEADBEEF;
      #1;
      checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== 8'(k + 5) || b4.out_index !== 2'(k)) begin errors++; $display("FAIL b2b_b k=%0d got v=%b d=%h i=%0d exp v=1 d=%h i=%0d", k, b4.out_valid, b4.out_data, b4.out_index, 8'(k + 5), k); end
      checks++; if (b4.frame_done !== (k == 0)) begin errors++; $display("FAIL b2b_fd k=%0d got %b exp %b", k, b4.frame_done, (k == 0)); end
    end
    cyc(); #1;
    checks++; if (b4.out_valid !== 1'b0 || b4.frame_done !== 1'b1) begin errors++; $display("FAIL b2b_end got v=%b fd=%b exp v=0 fd=1", b4.out_valid, b4.frame_done); end
    cyc();
  endtask

  task automatic test_reset_midframe();
    cyc();
    b4.in_valid = 1'b1; b4.data_in_flat = 32'h04030201; b4.out_ready = 1'b1;
    repeat (2) begin
      cyc();
      b4.in_valid = 1'b0;
    end
    cyc();
    rst = 1'b1;
    #1;
    checks++; if (b4.out_valid !== 1'b0 || b4.out_data !== 8'h00 || b4.out_index !== 2'd0) begin errors++; $display("FAIL rstmid_outputs got v=%b d=%h i=%0d exp v=0 d=00 i=0", b4.out_valid, b4.out_data, b4.out_index); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (b4.frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_fd got %b exp 0", b4.frame_done); end
    b4.in_valid = 1'b1; b4.data_in_flat = 32'h44332211;
    cyc();
    b4.in_valid = 1'b0;
    #1;
    checks++; if (b4.out_data !== 8'h11 || b4.out_index !== 2'd0 || b4.frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_fresh got d=%h i=%0d fd=%b exp d=11 i=0 fd=0", b4.out_data, b4.out_index, b4.frame_done); end
    repeat (5) cyc();
  endtask

  task automatic test_stages1();
    logic [15:0] prev;
    logic [15:0] cur;
    cyc();
    b1.in_valid = 1'b1; b1.data_in_flat = 16'hBEEF; b1.out_ready = 1'b1;
    cyc();
    b1.in_valid = 1'b0;
    #1;
    checks++; if (b1.out_valid !== 1'b1 || b1.out_data !== 16'hBEEF || b1.out_index !== 1'b0 || b1.out_last !== 1'b1) begin errors++; $display("FAIL s1_word got v=%b d=%h i=%0d l=%b exp v=1 d=beef i=0 l=1", b1.out_valid, b1.out_data, b1.out_index, b1.out_last); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL s1_in_ready got %b exp 1", b1.in_ready); end
    cyc(); #1;
    checks++; if (b1.out_valid !== 1'b0 || b1.frame_done !== 1'b1) begin errors++; $display("FAIL s1_fd got v=%b fd=%b exp v=0 fd=1", b1.out_valid, b1.frame_done); end
    prev = '0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      cur = 16'($urandom);
      b1.in_valid = 1'b1; b1.data_in_flat = cur;
      #1;
      checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL s1_stream_ready k=%0d got %b exp 1", k, b1.in_ready); end
      if (k > 0) begin
        checks++; if (b1.out_valid !== 1'b1 || b1.out_data !== prev || b1.out_last !== 1'b1) begin errors++; $display("FAIL s1_stream k=%0d got v=%b d=%h l=%b exp v=1 d=%h l=1", k, b1.out_valid, b1.out_data, b1.out_last, prev); end
        checks++; if (b1.frame_done !== (k >= 2)) begin errors++; $display("FAIL s1_stream_fd k=%0d got %b exp %b", k, b1.frame_done, (k >= 2)); end
      end
      prev = cur;
    end
    cyc();
    b1.in_valid = 1'b0;
    #1;
    checks++; if (b1.out_data !== prev) begin errors++; $display("FAIL s1_tail got %h exp %h", b1.out_data, prev); end
    repeat (2) cyc();
  endtask

  // Model: the current frame is a queue of words still to be delivered.
  task automatic test_random();
    logic [7:0]  q[$];
    int          mi  = 0;
    logic        mfd = 1'b0;
    logic [31:0] dv;
    logic        ev, el, er, xf, ld;
    repeat (2) cyc();
    for (int n = 0; n < 600; n++) begin
      cyc();
      dv = $urandom;
      b4.in_valid = (($urandom % 3) != 0);
      b4.out_ready = (($urandom % 4) != 0);
      b4.data_in_flat = dv;
      #1;
      ev = (q.size() != 0);
      el = (q.size() == 1);
      er = !ev || (b4.out_ready && el);
      checks++; if (b4.out_valid !== ev || b4.busy !== ev) begin errors++; $display("FAIL rnd_valid n=%0d got v=%b b=%b exp %b", n, b4.out_valid, b4.busy, ev); end
      checks++; if (b4.in_ready !== er) begin errors++; $display("FAIL rnd_in_ready n=%0d got %b exp %b", n, b4.in_ready, er); end
      checks++; if (b4.frame_done !== mfd) begin errors++; $display("FAIL rnd_fd n=%0d got %b exp %b", n, b4.frame_done, mfd); end
      checks++; if (b4.out_last !== el) begin errors++; $display("FAIL rnd_last n=%0d got %b exp %b", n, b4.out_last, el); end
      if (ev) begin
        checks++; if (b4.out_data !== q[0] || b4.out_index !== 2'(mi)) begin errors++; $display("FAIL rnd_word n=%0d got d=%h i=%0d exp d=%h i=%0d", n, b4.out_data, b4.out_index, q[0], mi); end
      end
      xf  = ev && b4.out_ready;
      ld  = b4.in_valid && er;
      mfd = xf && el;
      if (xf) begin
        void'(q.pop_front());
        mi++;
      end
      if (q.size() == 0) mi = 0;
      if (ld) begin
        for (int j = 0; j < 4; j++) q.push_back(dv[8*j +: 8]);
        mi = 0;
      end
    end
    b4.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_stages1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
